// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA/video), the arbiter and the SDRAM glue port.
// 'master' is the arbiter's view; 'slave' is the environment (requesters plus SDRAM glue).
`timescale 1ns/1ps
interface sdram_port_arbiter_if #(
    parameter int AW = 21,
    parameter int DW = 16
);
    logic          s_ready;

    logic          m0_stb;
    logic          m0_we;
    logic [1:0]    m0_sel;
    logic [AW:1]   m0_adr;
    logic [DW-1:0] m0_dat_i;
    logic          m0_ack;
    logic [DW-1:0] m0_dat_o;

    logic          m1_stb;
    logic          m1_we;
    logic [1:0]    m1_sel;
    logic [AW:1]   m1_adr;
    logic [DW-1:0] m1_dat_i;
    logic          m1_ack;
    logic [DW-1:0] m1_dat_o;

    logic          s_stb;
    logic          s_we;
    logic [1:0]    s_sel;
    logic [AW:1]   s_adr;
    logic [DW-1:0] s_dat_o;
    logic          s_ack;
    logic [DW-1:0] s_dat_i;

    logic [1:0]    gnt;

    modport master (
        input  s_ready,
        input  m0_stb, m0_we, m0_sel, m0_adr, m0_dat_i,
        output m0_ack, m0_dat_o,
        input  m1_stb, m1_we, m1_sel, m1_adr, m1_dat_i,
        output m1_ack, m1_dat_o,
        output s_stb, s_we, s_sel, s_adr, s_dat_o,
        input  s_ack, s_dat_i,
        output gnt
    );

    modport slave (
        output s_ready,
        output m0_stb, m0_we, m0_sel, m0_adr, m0_dat_i,
        input  m0_ack, m0_dat_o,
        output m1_stb, m1_we, m1_sel, m1_adr, m1_dat_i,
        input  m1_ack, m1_dat_o,
        input  s_stb, s_we, s_sel, s_adr, s_dat_o,
        output s_ack, s_dat_i,
        input  gnt
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter serialising CPU (m0) and DMA/video (m1) transactions onto one SDRAM glue port.
// Define SDRAM_ARB_RR_EN for round-robin ties; otherwise m0 has fixed priority.
`timescale 1ns/1ps

// Per-master return path: ack only reaches the current owner while it still requests.
module sdram_arb_port #(
    parameter int DW = 16
) (
    input  logic          stb_i,
    input  logic          gnt_i,
    input  logic          s_ack_i,
    input  logic [DW-1:0] s_dat_i,
    output logic          ack_o,
    output logic [DW-1:0] dat_o
);
    assign ack_o = s_ack_i & gnt_i & stb_i;
    assign dat_o = s_dat_i;
endmodule

module sdram_port_arbiter #(
    parameter int AW = 21,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sdram_port_arbiter_if.master bus
);
    localparam int NUM_M = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [NUM_M-1:0]           m_stb;
    logic [NUM_M-1:0]           m_we;
    logic [NUM_M-1:0][1:0]      m_sel;
    logic [NUM_M-1:0][AW:1]     m_adr;
    logic [NUM_M-1:0][DW-1:0]   m_dat;
    logic [NUM_M-1:0]           m_ack;
    logic [NUM_M-1:0][DW-1:0]   m_rdat;

    assign m_stb = {bus.m1_stb,   bus.m0_stb};
    assign m_we  = {bus.m1_we,    bus.m0_we};
    assign m_sel = {bus.m1_sel,   bus.m0_sel};
    assign m_adr = {bus.m1_adr,   bus.m0_adr};
    assign m_dat = {bus.m1_dat_i, bus.m0_dat_i};

    logic [1:0]    state_q, state_d;
    logic          s_stb_q, s_stb_d;
    logic          s_we_q,  s_we_d;
    logic [1:0]    s_sel_q, s_sel_d;
    logic [AW:1]   s_adr_q, s_adr_d;
    logic [DW-1:0] s_dat_q, s_dat_d;
    logic [1:0]    gnt_q,   gnt_d;
    logic          win;
    logic          owner;

`ifdef SDRAM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the master that did not own the port last wins.
    assign win = (&m_stb) ? ~last_q : ~m_stb[0];
`else
    assign win = ~m_stb[0];
`endif

    assign owner = gnt_q[1];

    always_comb begin
        state_d = state_q;
        s_stb_d = s_stb_q;
        s_we_d  = s_we_q;
        s_sel_d = s_sel_q;
        s_adr_d = s_adr_q;
        s_dat_d = s_dat_q;
        gnt_d   = gnt_q;
`ifdef SDRAM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.s_ready && (|m_stb)) begin
                    s_stb_d = 1'b1;
                    s_we_d  = m_we[win];
                    s_sel_d = m_sel[win];
                    s_adr_d = m_adr[win];
                    s_dat_d = m_dat[win];
                    gnt_d   = win ? 2'b10 : 2'b01;
                    state_d = ST_GRANT;
`ifdef SDRAM_ARB_RR_EN
                    last_d  = win;
`endif
                end
            end
            ST_GRANT: begin
                // Completion or abort both close the strobe; a late ack then finds gnt cleared.
                if (bus.s_ack || !m_stb[owner]) begin
                    s_stb_d = 1'b0;
                    gnt_d   = 2'b00;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_stb_q <= 1'b0;
            s_we_q  <= 1'b0;
            s_sel_q <= 2'b00;
            s_adr_q <= '0;
            s_dat_q <= '0;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            s_stb_q <= s_stb_d;
            s_we_q  <= s_we_d;
            s_sel_q <= s_sel_d;
            s_adr_q <= s_adr_d;
            s_dat_q <= s_dat_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef SDRAM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

    for (genvar g = 0; g < NUM_M; g++) begin : g_port
        sdram_arb_port #(.DW(DW)) u_port (
            .stb_i   (m_stb[g]),
            .gnt_i   (gnt_q[g]),
            .s_ack_i (bus.s_ack),
            .s_dat_i (bus.s_dat_i),
            .ack_o   (m_ack[g]),
            .dat_o   (m_rdat[g])
        );
    end

    assign bus.m0_ack   = m_ack[0];
    assign bus.m1_ack   = m_ack[1];
    assign bus.m0_dat_o = m_rdat[0];
    assign bus.m1_dat_o = m_rdat[1];

    assign bus.s_stb    = s_stb_q;
    assign bus.s_we     = s_we_q;
    assign bus.s_sel    = s_sel_q;
    assign bus.s_adr    = s_adr_q;
    assign bus.s_dat_o  = s_dat_q;
    assign bus.gnt      = gnt_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic. Honours SDRAM_ARB_RR_EN.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int AW = 21;
  localparam int DW = 16;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  sdram_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [1:0]          stb_r = '0;
  logic [1:0]          we_r  = '0;
  logic [1:0][1:0]     sel_r = '0;
  logic [1:0][AW:1]    adr_r = '0;
  logic [1:0][DW-1:0]  dat_r = '0;
  logic                s_ready_r = 1'b0;
  logic                s_ack_r   = 1'b0;
  logic [DW-1:0]       s_dat_r   = '0;

  assign bus.m0_stb = stb_r[0];  assign bus.m1_stb = stb_r[1];
  assign bus.m0_we  = we_r[0];   assign bus.m1_we  = we_r[1];
  assign bus.m0_sel = sel_r[0];  assign bus.m1_sel = sel_r[1];
  assign bus.m0_adr = adr_r[0];  assign bus.m1_adr = adr_r[1];
  assign bus.m0_dat_i = dat_r[0]; assign bus.m1_dat_i = dat_r[1];
  assign bus.s_ready = s_ready_r;
  assign bus.s_ack   = s_ack_r;
  assign bus.s_dat_i = s_dat_r;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic          we;
    logic [1:0]    sel;
    logic [AW:1]   adr;
    logic [DW-1:0] dat;
  } req_t;

  int   mo_owner;   // -1 = nobody holds the port
  bit   mo_gap;     // mandatory quiet cycle after a transaction
  bit   mo_last;    // 1 = m1 owned last
  req_t mo_req;

  function automatic int pick(input logic [1:0] r, input bit last);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return (RR_EN && !last) ? 1 : 0;
  endfunction

  function automatic req_t req_of(input int w);
    return {we_r[w], sel_r[w], adr_r[w], dat_r[w]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mo_owner <= -1;
      mo_gap   <= 1'b0;
      mo_last  <= 1'b1;
      mo_req   <= '0;
    end else if (mo_owner >= 0) begin
      if (!stb_r[mo_owner] || s_ack_r) begin
        mo_owner <= -1;
        mo_gap   <= 1'b1;
      end
    end else if (mo_gap) begin
      mo_gap <= 1'b0;
    end else if (s_ready_r && stb_r != 2'b00) begin
      mo_owner <= pick(stb_r, mo_last);
      mo_last  <= (pick(stb_r, mo_last) == 1);
      mo_req   <= req_of(pick(stb_r, mo_last));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("s_stb", bus.s_stb, mo_owner >= 0);
      chk("gnt", bus.gnt, (mo_owner == 0) ? 2'b01 : (mo_owner == 1) ? 2'b10 : 2'b00);
      chk("m0_ack", bus.m0_ack, (mo_owner == 0) && s_ack_r && stb_r[0]);
      chk("m1_ack", bus.m1_ack, (mo_owner == 1) && s_ack_r && stb_r[1]);
      chk("m0_dat_o", bus.m0_dat_o, s_dat_r);
      chk("m1_dat_o", bus.m1_dat_o, s_dat_r);
      if (mo_owner >= 0) begin
        chk("s_we", bus.s_we, mo_req.we);
        chk("s_sel", bus.s_sel, mo_req.sel);
        chk("s_adr", bus.s_adr, mo_req.adr);
        chk("s_dat_o", bus.s_dat_o, mo_req.dat);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (bus.s_stb !== 1'b1 && n < 20) begin
      step(); #1; n++;
    end
    if (bus.s_stb !== 1'b1) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; stb_r = '0; s_ack_r = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic new_req(input int x);
    stb_r[x] = 1'b1;
    we_r[x]  = 1'($urandom_range(1, 0));
    sel_r[x] = 2'($urandom_range(3, 1));
    adr_r[x] = AW'($urandom);
    dat_r[x] = DW'($urandom);
  endtask

  logic [1:0] ack_prev;
  logic [1:0] exp_g;

  initial begin
    // Reset values
    rst_n = 1'b0;
    step(); step(); #1;
    chk("rst_s_stb", bus.s_stb, 0);
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_s_we", bus.s_we, 0);
    chk("rst_s_sel", bus.s_sel, 2'b00);
    chk("rst_s_adr", bus.s_adr, 0);
    chk("rst_s_dat_o", bus.s_dat_o, 0);

    // T1: not ready -> no grant; ready -> grant next clock
    step();
    rst_n = 1'b1; s_ready_r = 1'b0;
    stb_r[0] = 1'b1; we_r[0] = 1'b0; sel_r[0] = 2'b11; adr_r[0] = 21'h0ABCD;
    repeat (3) begin step(); #1; chk("t1_not_ready", bus.s_stb, 0); end
    step(); s_ready_r = 1'b1; #1;
    chk("t1_before_edge", bus.s_stb, 0);
    step(); #1;
    chk("t1_stb", bus.s_stb, 1);
    chk("t1_gnt", bus.gnt, 2'b01);
    chk("t1_adr", bus.s_adr, 21'h0ABCD);
    step(); s_ack_r = 1'b1; s_dat_r = 16'h0001; #1;
    chk("t1_ack", bus.m0_ack, 1);
    step(); s_ack_r = 1'b0; stb_r[0] = 1'b0; #1;
    chk("t1_release", bus.s_stb, 0);

    // T2: read 0x1234, ack after 3 clocks
    step(); stb_r[0] = 1'b1; adr_r[0] = 21'h01234; #1;
    wait_grant("t2_grant");
    chk("t2_adr", bus.s_adr, 21'h01234);
    chk("t2_gnt", bus.gnt, 2'b01);
    step(); step();
    step(); s_ack_r = 1'b1; s_dat_r = 16'hBEEF; #1;
    chk("t2_m0_ack", bus.m0_ack, 1);
    chk("t2_m0_dat", bus.m0_dat_o, 16'hBEEF);
    chk("t2_m1_ack", bus.m1_ack, 0);
    step(); s_ack_r = 1'b0; #1;
    chk("t2_release_lo", bus.s_stb, 0);
    step(); #1;
    chk("t2_idle_lo", bus.s_stb, 0);
    step(); #1;
    chk("t2_regrant", bus.s_stb, 1);
    step(); s_ack_r = 1'b1; #1;
    step(); s_ack_r = 1'b0; stb_r[0] = 1'b0;

    // T3: both held requesting, 4 transactions
    do_reset();
    step(); s_ready_r = 1'b1; stb_r = 2'b11;
    we_r = 2'b00; adr_r[0] = 21'h00100; adr_r[1] = 21'h00200; #1;
    for (int i = 0; i < 4; i++) begin
      wait_grant("t3_grant");
      exp_g = (RR_EN && (i % 2 == 1)) ? 2'b10 : 2'b01;
      chk("t3_gnt", bus.gnt, exp_g);
      chk("t3_model_owner", mo_owner, (exp_g == 2'b10) ? 1 : 0);
      step(); s_ack_r = 1'b1; #1;
      step(); s_ack_r = 1'b0; #1;
    end
    stb_r = 2'b00;

    // T4: m1 byte write, sel toggled mid-grant
    step();
    stb_r[1] = 1'b1; we_r[1] = 1'b1; sel_r[1] = 2'b10; dat_r[1] = 16'hA500; adr_r[1] = 21'h00055; #1;
    wait_grant("t4_grant");
    chk("t4_gnt", bus.gnt, 2'b10);
    chk("t4_we", bus.s_we, 1);
    chk("t4_sel", bus.s_sel, 2'b10);
    chk("t4_dat", bus.s_dat_o, 16'hA500);
    step(); sel_r[1] = 2'b01; dat_r[1] = 16'h0000; #1;
    step(); #1;
    chk("t4_sel_held", bus.s_sel, 2'b10);
    chk("t4_dat_held", bus.s_dat_o, 16'hA500);
    step(); s_ack_r = 1'b1; #1;
    chk("t4_m1_ack", bus.m1_ack, 1);
    step(); s_ack_r = 1'b0; stb_r[1] = 1'b0;

    // T5: m0 aborts, late ack ignored, pending m1 served
    step(); stb_r = 2'b11; we_r = 2'b00; adr_r[0] = 21'h00777; adr_r[1] = 21'h00888; #1;
    wait_grant("t5_grant");
    chk("t5_gnt", bus.gnt, 2'b01);
    step(); stb_r[0] = 1'b0; #1;
    chk("t5_abort_ack", bus.m0_ack, 0);
    step(); s_ack_r = 1'b1; #1;
    chk("t5_late_m0_ack", bus.m0_ack, 0);
    chk("t5_late_m1_ack", bus.m1_ack, 0);
    chk("t5_release", bus.s_stb, 0);
    step(); s_ack_r = 1'b0; #1;
    wait_grant("t5_m1_grant");
    chk("t5_m1_gnt", bus.gnt, 2'b10);
    chk("t5_m1_adr", bus.s_adr, 21'h00888);
    step(); s_ack_r = 1'b1; #1;
    chk("t5_m1_ack", bus.m1_ack, 1);
    step(); s_ack_r = 1'b0; stb_r[1] = 1'b0;

    // T6: async reset mid-grant, then first tie goes to m0
    step(); stb_r[0] = 1'b1; #1;
    wait_grant("t6_grant");
    chk("t6_gnt", bus.gnt, 2'b01);
    step(); s_ack_r = 1'b1; stb_r[1] = 1'b1; #2;
    rst_n = 1'b0; #1;
    chk("t6_rst_stb", bus.s_stb, 0);
    chk("t6_rst_gnt", bus.gnt, 2'b00);
    chk("t6_rst_ack", bus.m0_ack, 0);
    step(); s_ack_r = 1'b0;
    step(); rst_n = 1'b1; #1;
    wait_grant("t6_after_grant");
    chk("t6_tie_m0", bus.gnt, 2'b01);
    step(); s_ack_r = 1'b1; #1;
    step(); s_ack_r = 1'b0; stb_r = 2'b00;

    // Randomized traffic
    ack_prev = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int x = 0; x < 2; x++) begin
        if (stb_r[x]) begin
          if (ack_prev[x]) begin
            if ($urandom_range(1, 0) == 1) new_req(x);
            else stb_r[x] = 1'b0;
          end else if ($urandom_range(29, 0) == 0) begin
            stb_r[x] = 1'b0;
          end else if ($urandom_range(7, 0) == 0) begin
            sel_r[x] = 2'($urandom_range(3, 0));
            dat_r[x] = DW'($urandom);
          end
        end else if ($urandom_range(2, 0) == 0) begin
          new_req(x);
        end
      end
      s_ready_r = ($urandom_range(9, 0) != 0);
      s_ack_r   = bus.s_stb && ($urandom_range(2, 0) == 0);
      s_dat_r   = DW'($urandom);
      #2;
      ack_prev = {bus.m1_ack, bus.m0_ack};
    end

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
